// File: rtl/mem_wb.sv
// MEM/WB pipeline register: load alignment, x0 write suppression,
// retire pulse and a 64-bit retired-instruction counter.
module mem_wb #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              rd_we_i,
    input  logic [REG_AW-1:0] rd_wa_i,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic              is_load_i,
    input  logic [1:0]        ld_size_i,
    input  logic              ld_uns_i,
    input  logic [1:0]        ld_off_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [1:0]        cnt_we_i,
    input  logic [DATA_W-1:0] cnt_wd_i,
    output logic              rd_we_o,
    output logic [REG_AW-1:0] rd_wa_o,
    output logic [DATA_W-1:0] rd_wd_o,
    output logic              retire_o,
    output logic [CNT_W-1:0]  instret_o
);

    localparam int HW = CNT_W / 2;

    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] sel_d;
    logic              cap_v;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              we_q;
    logic [REG_AW-1:0] wa_q;
    logic [DATA_W-1:0] wd_q;
    logic              ret_q;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        ld_b = 8'h00;
        unique case (ld_off_i)
            2'd0: ld_b = ld_data_i[7:0];
            2'd1: ld_b = ld_data_i[15:8];
            2'd2: ld_b = ld_data_i[23:16];
            2'd3: ld_b = ld_data_i[31:24];
        endcase
        ld_h = ld_off_i[1] ? ld_data_i[31:16]
                           : ld_data_i[15:0];
        ld_val = ld_data_i;
        unique case (1'b1)
            (ld_size_i == 2'b00):
                ld_val = {{24{~ld_uns_i & ld_b[7]}}, ld_b};
            (ld_size_i == 2'b01):
                ld_val = {{16{~ld_uns_i & ld_h[15]}}, ld_h};
            default:
                ld_val = ld_data_i;
        endcase
        sel_d = is_load_i ? ld_val : alu_res_i;
    end

    // Counter writes land on top of the increment, so a carry from
    // the low half still reaches an unwritten high half.
    always_comb begin
        cap_v   = valid_i & ~stall_i & ~flush_i;
        cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, cap_v};
        cnt_nxt = cnt_inc;
        if (cnt_we_i[0]) cnt_nxt[HW-1:0]     = cnt_wd_i;
        if (cnt_we_i[1]) cnt_nxt[CNT_W-1:HW] = cnt_wd_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q  <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
            ret_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            if (flush_i) begin
                we_q  <= 1'b0;
                wa_q  <= '0;
                wd_q  <= '0;
                ret_q <= 1'b0;
            end else if (stall_i) begin
                ret_q <= 1'b0;
            end else begin
                we_q  <= valid_i & rd_we_i & (|rd_wa_i);
                wa_q  <= valid_i ? rd_wa_i : '0;
                wd_q  <= valid_i ? sel_d : '0;
                ret_q <= valid_i;
            end
        end
    end

    assign rd_we_o   = we_q;
    assign rd_wa_o   = wa_q;
    assign rd_wd_o   = wd_q;
    assign retire_o  = ret_q;
    assign instret_o = cnt_q;

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed scenarios plus randomized
// traffic against a behavioural model of the writeback stage.
module tb_mem_wb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        rd_we_i;
    logic [4:0]  rd_wa_i;
    logic [31:0] alu_res_i;
    logic        is_load_i;
    logic [1:0]  ld_size_i;
    logic        ld_uns_i;
    logic [1:0]  ld_off_i;
    logic [31:0] ld_data_i;
    logic        stall_i;
    logic        flush_i;
    logic [1:0]  cnt_we_i;
    logic [31:0] cnt_wd_i;
    logic        rd_we_o;
    logic [4:0]  rd_wa_o;
    logic [31:0] rd_wd_o;
    logic        retire_o;
    logic [63:0] instret_o;

    int n_vec = 0;
    int n_err = 0;

    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_ret;
    logic [63:0] m_cnt;

    mem_wb dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .rd_we_i(rd_we_i), .rd_wa_i(rd_wa_i),
        .alu_res_i(alu_res_i), .is_load_i(is_load_i),
        .ld_size_i(ld_size_i), .ld_uns_i(ld_uns_i),
        .ld_off_i(ld_off_i), .ld_data_i(ld_data_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .cnt_we_i(cnt_we_i), .cnt_wd_i(cnt_wd_i),
        .rd_we_o(rd_we_o), .rd_wa_o(rd_wa_o),
        .rd_wd_o(rd_wd_o), .retire_o(retire_o),
        .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

    // Load result from the architectural rule: shift, mask, extend.
    function automatic logic [31:0] load_val(
        input logic [1:0] size, input logic uns,
        input logic [1:0] off, input logic [31:0] data);
        longint v;
        case (size)
            2'b00: begin
                v = (longint'(data) >> (8 * off)) & 'hFF;
                if (!uns && v >= 128) v = v - 256;
            end
            2'b01: begin
                v = (longint'(data) >> (16 * (off / 2))) & 'hFFFF;
                if (!uns && v >= 32768) v = v - 65536;
            end
            default: v = longint'(data);
        endcase
        return v[31:0];
    endfunction

    task automatic idle();
        rst_i = 0; valid_i = 0; rd_we_i = 0; rd_wa_i = 0;
        alu_res_i = 0; is_load_i = 0; ld_size_i = 0;
        ld_uns_i = 0; ld_off_i = 0; ld_data_i = 0;
        stall_i = 0; flush_i = 0; cnt_we_i = 0; cnt_wd_i = 0;
    endtask

    // Advance one edge and update the model from the sampled inputs.
    task automatic tick();
        logic [63:0] nc;
        bit cap;
        @(posedge clk_i);
        if (rst_i) begin
            m_we = 0; m_wa = 0; m_wd = 0; m_ret = 0; m_cnt = 0;
        end else begin
            cap = !flush_i && !stall_i && valid_i;
            nc = m_cnt + (cap ? 64'd1 : 64'd0);
            if (cnt_we_i[0]) nc[31:0]  = cnt_wd_i;
            if (cnt_we_i[1]) nc[63:32] = cnt_wd_i;
            m_cnt = nc;
            if (flush_i) begin
                m_we = 0; m_wa = 0; m_wd = 0; m_ret = 0;
            end else if (stall_i) begin
                m_ret = 0;
            end else begin
                m_we  = valid_i && rd_we_i && rd_wa_i != 0;
                m_wa  = valid_i ? rd_wa_i : 5'd0;
                m_wd  = !valid_i ? 32'd0 :
                        is_load_i ? load_val(ld_size_i, ld_uns_i,
                                             ld_off_i, ld_data_i)
                                  : alu_res_i;
                m_ret = valid_i;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); rst_i = 1;
        tick(); tick();
        n_vec++;
        if ({rd_we_o, rd_wa_o, rd_wd_o, retire_o} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_out got %b/%0d/%h/%b want 0",
                     rd_we_o, rd_wa_o, rd_wd_o, retire_o);
        end
        n_vec++;
        if (instret_o !== 64'd0) begin
            n_err++;
            $display("FAIL reset_cnt got %h want 0", instret_o);
        end
        idle();
    endtask

    task automatic test_alu();
        logic [63:0] c0;
        c0 = m_cnt;
        idle(); valid_i = 1; rd_we_i = 1; rd_wa_i = 5;
        alu_res_i = 32'h12345678;
        tick(); idle();
        n_vec++;
        if (rd_we_o !== 1'b1 || rd_wa_o !== 5'd5 ||
            rd_wd_o !== 32'h12345678 || retire_o !== 1'b1) begin
            n_err++;
            $display("FAIL alu got %b/%0d/%h/%b want 1/5/12345678/1",
                     rd_we_o, rd_wa_o, rd_wd_o, retire_o);
        end
        n_vec++;
        if (instret_o !== c0 + 64'd1) begin
            n_err++;
            $display("FAIL alu_cnt got %h want %h", instret_o, c0 + 1);
        end
    endtask

    task automatic test_loads();
        logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic        un [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  of [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd2};
        logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080,
                                32'hFFFF80FF, 32'h00007F01,
                                32'h80FF7F01};
        for (int i = 0; i < 5; i++) begin
            idle(); valid_i = 1; rd_we_i = 1; rd_wa_i = 10;
            is_load_i = 1; ld_data_i = 32'h80FF7F01;
            alu_res_i = 32'hDEADBEEF;
            ld_size_i = sz[i]; ld_uns_i = un[i]; ld_off_i = of[i];
            tick();
            n_vec++;
            if (rd_wd_o !== ex[i] || rd_we_o !== 1'b1) begin
                n_err++;
                $display("FAIL load[%0d] got %h we=%b want %h we=1",
                         i, rd_wd_o, rd_we_o, ex[i]);
            end
        end
        idle();
    endtask

    task automatic test_x0();
        logic [63:0] c0;
        c0 = m_cnt;
        idle(); valid_i = 1; rd_we_i = 1; rd_wa_i = 0;
        alu_res_i = 32'h55AA55AA;
        tick(); idle();
        n_vec++;
        if (rd_we_o !== 1'b0 || retire_o !== 1'b1 ||
            instret_o !== c0 + 64'd1) begin
            n_err++;
            $display("FAIL x0 got we=%b ret=%b cnt=%h want 0/1/%h",
                     rd_we_o, retire_o, instret_o, c0 + 1);
        end
    endtask

    task automatic test_stall_flush();
        logic [63:0] c0;
        c0 = m_cnt;
        idle(); valid_i = 1; rd_we_i = 1; rd_wa_i = 7;
        alu_res_i = 32'hCAFEF00D;
        tick();
        rd_wa_i = 9; alu_res_i = 32'h11111111; stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (rd_we_o !== 1'b1 || rd_wa_o !== 5'd7 ||
                rd_wd_o !== 32'hCAFEF00D || retire_o !== 1'b0 ||
                instret_o !== c0 + 64'd1) begin
                n_err++;
                $display("FAIL stall[%0d] got %b/%0d/%h/%b/%h", i,
                         rd_we_o, rd_wa_o, rd_wd_o, retire_o, instret_o);
            end
        end
        stall_i = 0; flush_i = 1;
        tick(); idle();
        n_vec++;
        if ({rd_we_o, rd_wa_o, rd_wd_o, retire_o} !== 39'd0 ||
            instret_o !== c0 + 64'd1) begin
            n_err++;
            $display("FAIL flush got %b/%0d/%h/%b/%h want bubble cnt %h",
                     rd_we_o, rd_wa_o, rd_wd_o, retire_o, instret_o,
                     c0 + 1);
        end
    endtask

    task automatic test_counter();
        idle(); cnt_we_i = 2'b11; cnt_wd_i = 32'hFFFFFFFF;
        tick();
        idle(); valid_i = 1; rd_we_i = 1; rd_wa_i = 3;
        tick(); idle();
        n_vec++;
        if (instret_o !== 64'd0) begin
            n_err++;
            $display("FAIL cnt_wrap got %h want 0", instret_o);
        end
        cnt_we_i = 2'b01; cnt_wd_i = 32'hFFFFFFFF;
        tick(); idle();
        n_vec++;
        if (instret_o !== 64'h00000000_FFFFFFFF) begin
            n_err++;
            $display("FAIL cnt_lo got %h want 00000000ffffffff",
                     instret_o);
        end
        valid_i = 1; rd_we_i = 1; rd_wa_i = 4;
        cnt_we_i = 2'b10; cnt_wd_i = 32'h5;
        tick(); idle();
        n_vec++;
        if (instret_o !== 64'h00000005_00000000) begin
            n_err++;
            $display("FAIL cnt_hi got %h want 0000000500000000",
                     instret_o);
        end
        valid_i = 1; stall_i = 1; flush_i = 1;
        cnt_we_i = 2'b01; cnt_wd_i = 32'h77;
        tick(); idle();
        n_vec++;
        if (instret_o !== 64'h00000005_00000077) begin
            n_err++;
            $display("FAIL cnt_flush_wr got %h want 0000000500000077",
                     instret_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        idle(); valid_i = 1; rd_we_i = 1; rd_wa_i = 12;
        alu_res_i = 32'hA5A5A5A5;
        tick();
        stall_i = 1;
        tick();
        rst_i = 1; flush_i = 1; cnt_we_i = 2'b11;
        cnt_wd_i = 32'h12345678;
        tick();
        n_vec++;
        if ({rd_we_o, rd_wa_o, rd_wd_o, retire_o} !== 39'd0 ||
            instret_o !== 64'd0) begin
            n_err++;
            $display("FAIL rst_stall got %b/%0d/%h/%b/%h want 0",
                     rd_we_o, rd_wa_o, rd_wd_o, retire_o, instret_o);
        end
        idle(); valid_i = 1; rd_we_i = 1; rd_wa_i = 9;
        alu_res_i = 32'h0BADF00D;
        tick(); idle();
        n_vec++;
        if (rd_we_o !== 1'b1 || rd_wa_o !== 5'd9 ||
            rd_wd_o !== 32'h0BADF00D || retire_o !== 1'b1 ||
            instret_o !== 64'd1) begin
            n_err++;
            $display("FAIL rst_after got %b/%0d/%h/%b/%h want 1/9/0badf00d/1/1",
                     rd_we_o, rd_wa_o, rd_wd_o, retire_o, instret_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_i     = ($urandom_range(0, 49) == 0);
            valid_i   = ($urandom_range(0, 3) != 0);
            rd_we_i   = ($urandom_range(0, 3) != 0);
            rd_wa_i   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            alu_res_i = $urandom;
            is_load_i = $urandom_range(0, 1) == 1;
            ld_size_i = 2'($urandom);
            ld_uns_i  = $urandom_range(0, 1) == 1;
            ld_off_i  = 2'($urandom);
            ld_data_i = $urandom;
            stall_i   = ($urandom_range(0, 4) == 0);
            flush_i   = ($urandom_range(0, 7) == 0);
            cnt_we_i  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            cnt_wd_i  = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF
                                                    : $urandom;
            tick();
            n_vec++;
            if (rd_we_o !== m_we || rd_wa_o !== m_wa ||
                rd_wd_o !== m_wd || retire_o !== m_ret ||
                instret_o !== m_cnt) begin
                n_err++;
                $display("FAIL random[%0d] got %b/%0d/%h/%b/%h want %b/%0d/%h/%b/%h",
                         i, rd_we_o, rd_wa_o, rd_wd_o, retire_o, instret_o,
                         m_we, m_wa, m_wd, m_ret, m_cnt);
            end
        end
        idle();
    endtask

    initial begin
        m_we = 0; m_wa = 0; m_wd = 0; m_ret = 0; m_cnt = 0;
        test_reset();
        test_alu();
        test_loads();
        test_x0();
        test_stall_flush();
        test_counter();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
